mod_dp: RTL and testbench

- Datapath for the repeated-subtraction modulo unit. Computes a_in mod b_in, and the quotient as a by-product.
- Sits directly downstream of the modulo control unit. It consumes that unit's we/selA/saveSub/saveResult strobes and returns the ltb status bit that unit branches on.
- Operands are captured once per operation; the result is held until the next operation completes.

---
 rtl/mod_dp.sv | 118 +++++++++++
 tb/tb_mod_dp.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/mod_dp.sv
// mod_dp: repeated-subtraction modulo datapath.
// Computes a_in mod b_in, with the quotient as a by-product, under the
// control of an external unit that drives we/selA/saveSub/saveResult and
// branches on ltb.
module mod_dp #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             we,
    input  logic             selA,
    input  logic             saveSub,
    input  logic             saveResult,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             ltb,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] quotient,
    output logic             result_valid,
    output logic             div_by_zero
);

    // Working value carries one extra bit so the borrow shows up as a sign bit.
    logic [WIDTH:0]   r_w;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_s;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] r_quotient;
    logic             r_div_by_zero;
    logic             r_result_valid;

    logic [WIDTH:0]   w_diff;
    logic             w_bzero;
    logic             w_ltb;

    // Subtraction result, zero-divisor flag and loop-exit status.
    always_comb begin
        w_diff  = r_w - {1'b0, r_b};
        w_bzero = (r_b == '0);
        w_ltb   = r_w[WIDTH] | w_bzero;
    end

    // Working register: load the dividend on start, otherwise subtract the divisor.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_w <= '0;
        end else if (we) begin
            if (selA) begin
                r_w <= {1'b0, a_in};
            end else begin
                r_w <= w_diff;
            end
        end
    end

    // Divisor register: captured only at operation start.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_b <= '0;
        end else if (we && selA) begin
            r_b <= b_in;
        end
    end

    // Saved remainder: seeded with the dividend, then follows W while it stays non-negative.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_s <= '0;
        end else if (saveSub) begin
            if (we && selA) begin
                r_s <= a_in;
            end else if (!selA && !w_ltb) begin
                r_s <= r_w[WIDTH-1:0];
            end
        end
    end

    // Quotient counter: cleared on load, counts each accepted subtraction.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_q <= '0;
        end else if (we && selA) begin
            r_q <= '0;
        end else if (saveSub && !selA && !w_ltb) begin
            r_q <= r_q + WIDTH'(1);
        end
    end

    // Output registers: commit the finished operation and hold until the next commit.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_result      <= '0;
            r_quotient    <= '0;
            r_div_by_zero <= 1'b0;
        end else if (saveResult) begin
            r_result      <= r_s;
            r_quotient    <= r_q;
            r_div_by_zero <= w_bzero;
        end
    end

    // One-cycle valid pulse following each commit.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_result_valid <= 1'b0;
        end else begin
            r_result_valid <= saveResult;
        end
    end

    assign ltb          = w_ltb;
    assign result       = r_result;
    assign quotient     = r_quotient;
    assign div_by_zero  = r_div_by_zero;
    assign result_valid = r_result_valid;

endmodule

// File: tb/tb_mod_dp.sv
// tb_mod_dp: drives control-unit-equivalent strobes into mod_dp and checks
// results against plain integer division through a scoreboard queue.
module tb_mod_dp;

    localparam int W = 8;

    logic         CLK = 1'b0;
    logic         reset;
    logic         we, selA, saveSub, saveResult;
    logic [W-1:0] a_in, b_in;
    logic         ltb;
    logic [W-1:0] result, quotient;
    logic         result_valid, div_by_zero;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [W-1:0] res;
        logic [W-1:0] quo;
        logic         dbz;
    } exp_t;

    exp_t exp_q[$];

    mod_dp #(.WIDTH(W)) dut (
        .CLK(CLK), .reset(reset), .we(we), .selA(selA), .saveSub(saveSub),
        .saveResult(saveResult), .a_in(a_in), .b_in(b_in), .ltb(ltb),
        .result(result), .quotient(quotient), .result_valid(result_valid),
        .div_by_zero(div_by_zero)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a result.
    logic prev_valid = 1'b0;
    always @(negedge CLK) begin
        if (result_valid) begin
            exp_t e;
            check("valid_pulse_width", int'(prev_valid), 0);
            if (exp_q.size() == 0) begin
                check("unexpected_result", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("result", int'(result), int'(e.res));
                check("quotient", int'(quotient), int'(e.quo));
                check("div_by_zero", int'(div_by_zero), int'(e.dbz));
            end
        end
        prev_valid <= result_valid;
    end

    task automatic idle();
        we = 0; selA = 0; saveSub = 0; saveResult = 0;
    endtask

    // One full operation, sequenced like the control unit. If abort_after > 0
    // the loop stops after that many subtracts and no commit is issued.
    task automatic run_op(input int a, input int b, input bit scramble, input int abort_after);
        int  cnt, k, qx;
        bit  done, exp_ltb;
        exp_t e;
        qx = (b == 0) ? 0 : a / b;
        @(negedge CLK);
        we = 1; selA = 1; saveSub = 1; saveResult = 0;
        a_in = W'(a); b_in = W'(b);
        @(posedge CLK);
        cnt = 1; k = 0; done = 0;
        while (!done) begin
            @(negedge CLK);
            we = 1; selA = 0; saveSub = 0;
            if (scramble) begin
                a_in = W'($urandom); b_in = W'($urandom);
            end
            @(posedge CLK);
            cnt++; k++;
            @(negedge CLK);
            we = 0; saveSub = 1;
            exp_ltb = (b == 0) || (k * b > a);
            check("ltb_at_check", int'(ltb), int'(exp_ltb));
            done = ltb;
            @(posedge CLK);
            cnt++;
            if (abort_after > 0 && k == abort_after) return;
            if (k > 2 * (1 << W)) begin
                check("loop_bound", k, qx + 1);
                done = 1;
            end
        end
        @(negedge CLK);
        idle();
        saveResult = 1;
        e.res = W'((b == 0) ? a : a % b);
        e.quo = W'(qx);
        e.dbz = (b == 0);
        exp_q.push_back(e);
        @(posedge CLK);
        cnt++;
        #1;
        check("latency", cnt, 2 * (qx + 1) + 2);
        check("valid_after_commit", int'(result_valid), 1);
        @(negedge CLK);
        idle();
    endtask

    initial begin
        idle();
        a_in = '0; b_in = '0;
        reset = 1;
        #12;
        check("reset_result", int'(result), 0);
        check("reset_quotient", int'(quotient), 0);
        check("reset_dbz", int'(div_by_zero), 0);
        check("reset_valid", int'(result_valid), 0);
        check("reset_ltb", int'(ltb), 1);
        @(negedge CLK);
        reset = 0;

        run_op(7, 3, 0, 0);
        run_op(2, 3, 0, 0);
        run_op(6, 3, 0, 0);
        run_op(45, 0, 0, 0);
        run_op(255, 1, 1, 0);
        run_op(0, 5, 0, 0);
        run_op(255, 255, 0, 0);

        // Held output must survive an unrelated partial operation until reset.
        run_op(200, 7, 0, 3);
        #2;
        check("hold_before_reset", int'(result), 255 % 255);
        check("hold_quotient_before_reset", int'(quotient), 1);
        reset = 1;
        #1;
        check("async_reset_result", int'(result), 0);
        check("async_reset_quotient", int'(quotient), 0);
        check("async_reset_valid", int'(result_valid), 0);
        check("async_reset_ltb", int'(ltb), 1);
        idle();
        @(negedge CLK);
        reset = 0;
        run_op(200, 7, 0, 0);

        for (int i = 0; i < 30; i++) begin
            int a, b;
            a = int'($urandom_range(0, (1 << W) - 1));
            b = (i % 7 == 3) ? 0 : int'($urandom_range(1, (1 << W) - 1));
            run_op(a, b, bit'($urandom_range(0, 1)), 0);
        end

        repeat (3) @(posedge CLK);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #2000000;
        $display("FAIL timeout: got no finish, expected finish before time limit");
        $fatal(1, "timeout");
    end

endmodule
